// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between register-level logic and interval_timer_ctrl.
// TIMER_STICKY_IRQ_EN adds the irq_clr/irq pair.
interface interval_timer_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
);
  logic             start;
  logic             stop;
  logic             mode;
  logic [CNT_W-1:0] period;
  logic [PRE_W-1:0] prescale;
  logic             busy;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             done;
`ifdef TIMER_STICKY_IRQ_EN
  logic             irq_clr;
  logic             irq;
`endif

  modport master (
    output start, stop, mode, period, prescale,
`ifdef TIMER_STICKY_IRQ_EN
    output irq_clr, input irq,
`endif
    input  busy, tick, count, tc, done
  );

  modport slave (
    input  start, stop, mode, period, prescale,
`ifdef TIMER_STICKY_IRQ_EN
    input  irq_clr, output irq,
`endif
    output busy, tick, count, tc, done
  );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: prescaled up-counter, one-shot or periodic, latched config.
// Optional sticky interrupt under TIMER_STICKY_IRQ_EN.
module interval_timer_ctrl #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  interval_timer_ctrl_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             mode_s_q, mode_s_d;
  logic [CNT_W-1:0] period_s_q, period_s_d;
  logic [PRE_W-1:0] prescale_s_q, prescale_s_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             tick;
  logic             last;

  assign tick = (state_q == RUN) && (pre_q == prescale_s_q);
  assign last = (count_q == period_s_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pre_d        = pre_q;
    mode_s_d     = mode_s_q;
    period_s_d   = period_s_q;
    prescale_s_d = prescale_s_q;
    tc_d         = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        pre_d   = '0;
        if (bus.start && !bus.stop && (bus.period != '0)) begin
          mode_s_d     = bus.mode;
          period_s_d   = bus.period;
          prescale_s_d = bus.prescale;
          state_d      = RUN;
        end
      end
      RUN: begin
        // stop outranks a coincident terminal tick: no pulses on abort
        if (bus.stop) begin
          state_d = IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (tick) begin
          pre_d = '0;
          if (last) begin
            count_d = '0;
            tc_d    = 1'b1;
            if (!mode_s_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      pre_q        <= '0;
      mode_s_q     <= 1'b0;
      period_s_q   <= '0;
      prescale_s_q <= '0;
      tc_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pre_q        <= pre_d;
      mode_s_q     <= mode_s_d;
      period_s_q   <= period_s_d;
      prescale_s_q <= prescale_s_d;
      tc_q         <= tc_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.tick  = tick;
  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

`ifdef TIMER_STICKY_IRQ_EN
  logic irq_q, irq_d;

  // Set wins over clear whether the clear lands on the edge raising tc or while tc is visible
  always_comb irq_d = tc_d | tc_q | (irq_q & ~bus.irq_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Bench for interval_timer_ctrl: directed scenarios then random traffic,
// checked against an elapsed-time model of the timer.
module tb_interval_timer_ctrl;
  localparam int CW = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  interval_timer_ctrl_if #(.CNT_W(CW), .PRE_W(PW)) bus ();
  interval_timer_ctrl #(.CNT_W(CW), .PRE_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0;
  int total  = 0;

  // Model: run flag, clocks elapsed since the accepting edge, latched N/P/mode.
  bit m_run, m_mode, m_tc, m_done, m_irq;
  int m_el, m_n, m_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int exp_count();
    return m_run ? (m_el / (m_p + 1)) % m_n : 0;
  endfunction

  function automatic bit exp_tick();
    return m_run && ((m_el % (m_p + 1)) == m_p);
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".busy"},  32'(bus.busy),  32'(m_run));
    chk({tag, ".tick"},  32'(bus.tick),  32'(exp_tick()));
    chk({tag, ".count"}, 32'(bus.count), 32'(exp_count()));
    chk({tag, ".tc"},    32'(bus.tc),    32'(m_tc));
    chk({tag, ".done"},  32'(bus.done),  32'(m_done));
`ifdef TIMER_STICKY_IRQ_EN
    chk({tag, ".irq"},   32'(bus.irq),   32'(m_irq));
`endif
  endtask

  task automatic model_reset();
    m_run = 0; m_el = 0; m_n = 1; m_p = 0; m_mode = 0;
    m_tc = 0; m_done = 0; m_irq = 0;
  endtask

  task automatic model_step();
    int  per;
    bit  ntc, ndone, clr;
    ntc = 0; ndone = 0; clr = 0;
`ifdef TIMER_STICKY_IRQ_EN
    clr = bus.irq_clr;
`endif
    per = m_n * (m_p + 1);
    if (m_run) begin
      if (bus.stop) m_run = 0;
      else begin
        if ((m_el % per) == per - 1) begin
          ntc = 1;
          if (!m_mode) begin m_run = 0; ndone = 1; end
        end
        m_el++;
      end
    end else if (bus.start && !bus.stop && bus.period != 0) begin
      m_run = 1; m_el = 0;
      m_n = int'(bus.period); m_p = int'(bus.prescale); m_mode = bus.mode;
    end
    m_irq  = ntc | m_tc | (m_irq & !clr);
    m_tc   = ntc;
    m_done = ndone;
  endtask

  task automatic drive(input bit st, input bit sp, input bit md, input int n, input int p);
    bus.start = st; bus.stop = sp; bus.mode = md;
    bus.period = CW'(n); bus.prescale = PW'(p);
  endtask

  // Check current outputs, clock once, advance model, return to the falling edge.
  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check_outputs(tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0);
`ifdef TIMER_STICKY_IRQ_EN
    bus.irq_clr = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;

    // One-shot N=4 P=0
    drive(1, 0, 0, 4, 0); cycles("os_start", 1);
    drive(0, 0, 0, 4, 0); cycles("os_run", 7);

    // Periodic N=3 P=1 for 20 clocks, then stop
    drive(1, 0, 1, 3, 1); cycles("per_start", 1);
    drive(0, 0, 1, 3, 1); cycles("per_run", 20);
    drive(0, 1, 1, 3, 1); cycles("per_stop", 1);
    drive(0, 0, 0, 0, 0); cycles("per_idle", 2);

    // Periodic N=5 P=0: stop on the terminal tick (count 4)
    drive(1, 0, 1, 5, 0); cycles("st_start", 1);
    drive(0, 0, 1, 5, 0); cycles("st_run", 4);
    chk("st_at4.count", 32'(bus.count), 32'd4);
    chk("st_at4.tick",  32'(bus.tick),  32'd1);
    drive(0, 1, 1, 5, 0); cycles("st_stop", 1);
    drive(0, 0, 0, 0, 0); cycles("st_after", 3);

    // Zero period ignored; start+stop together ignored
    drive(1, 0, 1, 0, 2); cycles("zero_n", 3);
    drive(1, 1, 1, 3, 0); cycles("start_stop", 2);

    // Retrigger attempt with a different config is ignored
    drive(1, 0, 1, 3, 0); cycles("rt_start", 1);
    drive(1, 0, 0, 6, 2); cycles("rt_again", 1);
    drive(0, 0, 0, 7, 3); cycles("rt_run", 8);
    drive(0, 1, 0, 0, 0); cycles("rt_stop", 1);

    // Asynchronous reset mid-run at count 2, then a clean restart
    drive(1, 0, 1, 5, 0); cycles("ar_start", 1);
    drive(0, 0, 1, 5, 0); cycles("ar_run", 2);
    chk("ar_pre.count", 32'(bus.count), 32'd2);
    #2 rst = 1'b0;
    #1 model_reset();
    check_outputs("ar_async");
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 2, 1); cycles("ar_restart", 1);
    drive(0, 0, 0, 2, 1); cycles("ar_rerun", 6);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
`ifdef TIMER_STICKY_IRQ_EN
      bus.irq_clr = ($urandom_range(0, 3) == 0);
`endif
      cycles("rand", 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
- Controller that sequences a prescaled, enable-gated up-counter as a programmable interval timer.
- Latches the configuration on a start pulse and runs the counter in one-shot or periodic mode.
- Generates the prescaled count enable, terminal-count and done pulses.
- Sits between CPU/register-level control logic and the free counter datapath; replaces ad-hoc enable wiring around counters.

Parameters:
CNT_W, 16, width of interval counter and period input
PRE_W, 8, width of prescaler and prescale input

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
start  input  1  start request, sampled each rising edge
stop  input  1  abort request, sampled each rising edge
mode  input  1  0 = one-shot, 1 = periodic; latched on accepted start
period  input  CNT_W  interval length N in ticks, latched on accepted start; N = 0 invalid
prescale  input  PRE_W  prescale value P, latched on accepted start; tick every P+1 clocks
busy  output  1  high while in RUN
tick  output  1  prescaled count enable, combinational decode of registered state
count  output  CNT_W  current interval count
tc  output  1  registered terminal-count pulse, one clock wide
done  output  1  registered one-shot completion pulse, one clock wide

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - count, prescaler, shadow regs, tc and done all 0; busy = 0.
  - Reset mid-RUN aborts immediately with no pulse.
- States: IDLE, RUN (binary encoded, 1 bit sufficient).
- IDLE:
  - count = 0, prescaler = 0.
  - start = 1, stop = 0 and period != 0 → latch mode/period/prescale into shadow regs; count <= 0, prescaler <= 0; go to RUN.
  - start with period = 0 is ignored: stay IDLE, no pulses.
- RUN:
  - busy = 1.
  - tick = (prescaler == prescale_s).
  - On tick: prescaler <= 0; otherwise prescaler <= prescaler + 1.
  - On tick with count != period_s − 1: count <= count + 1.
  - On tick with count == period_s − 1: count <= 0 and tc <= 1 next cycle.
    - Periodic: stay in RUN.
    - One-shot: go to IDLE and assert done <= 1 in the same cycle as tc.
- Pulses: tc and done are high for exactly one clock; they default to 0 every other cycle.
- stop in RUN:
  - Go to IDLE; count <= 0, prescaler <= 0.
  - No tc or done, even if a terminal tick coincides (stop has priority).
- start while in RUN is ignored; there is no retrigger and the shadow regs are unchanged.
- start and stop together in IDLE: stop wins, stay IDLE.
- Config inputs may change freely during RUN; only the shadow copies are used.
- Timing from the edge that accepts start:
  - busy rises after that edge.
  - First tick occurs P clocks later.
  - Periodic tc period is N·(P+1) clocks.
- Arithmetic: all counters are unsigned and wrap only through the explicit terminal compare. count never exceeds period_s − 1.

Optional Feature:
- Macro TIMER_STICKY_IRQ_EN.
- Defined: adds ports irq_clr (input, 1) and irq (output, 1, registered).
  - irq sets on every tc.
  - irq clears when irq_clr = 1.
  - Set wins if tc and irq_clr coincide.
  - irq resets to 0 and is unaffected by stop.
- Undefined: neither port exists; no sticky logic is present.

Test Plan:
- One-shot, N=4, P=0, start pulsed one cycle:
  - busy high for 4 clocks; count shows 0,1,2,3.
  - tc and done both high for exactly 1 clock on the 4th edge after start; busy low the same cycle.
- Periodic, N=3, P=1, run for 20 clocks:
  - tick every 2nd clock; count cycles 0,1,2.
  - tc pulses every 6 clocks; done never asserts.
- Periodic, N=5, P=0: assert stop on the clock where count = 4 and tick = 1 → no tc; state IDLE; count = 0 next cycle.
- start with period = 0 → busy stays 0, no tc or done. A second start during RUN with different config → original period is kept.
- Drive rst low asynchronously mid-RUN (count = 2) → all outputs 0 immediately. After release, a new start runs normally.
- With TIMER_STICKY_IRQ_EN:
  - irq rises with the first tc and holds.
  - irq_clr asserted in the same cycle as the next tc → irq stays 1.
  - irq_clr alone → irq 0 next cycle.
